// File: rtl/ii_pkg.sv
// Shared constants and types for the integral-image frame store.
// Used by the writer (integral_image_builder) and the display reader.
//   II_WIDTH x II_HEIGHT frame of PIX_W-bit pixels, DATA_W-bit integral
//   values, ADDR_W-bit RAM addresses (address = y*II_WIDTH + x).
package ii_pkg;

  localparam int II_WIDTH  = 160;
  localparam int II_HEIGHT = 120;
  localparam int PIX_W     = 4;
  localparam int DATA_W    = 20;   // 160*120*15 = 288000 < 2^20
  localparam int ADDR_W    = 15;
  localparam int II_PIXELS = II_WIDTH * II_HEIGHT;

  localparam int COL_W = $clog2(II_WIDTH);
  localparam int ROW_W = $clog2(II_HEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ii_state_t;

  // Stage-1 pipeline register: everything stage 2 needs besides lb_rdata.
  typedef struct packed {
    logic              valid;
    logic [COL_W-1:0]  col;
    logic              row0;
    logic              last;
    logic [DATA_W-1:0] row_sum;
    logic [ADDR_W-1:0] addr;
  } ii_stage1_t;

endpackage

// File: rtl/integral_image_builder_if.sv
// Pixel-stream input and RAM-write output bundle of the integral-image
// writer.
//   master : camera front end / RAM side (drives frame_start, pix_valid,
//            pix_data; observes the write bus and status)
//   slave  : integral_image_builder (drives wr_en, wr_addr, wr_data,
//            busy, frame_done, overrun)
interface integral_image_builder_if;
  import ii_pkg::*;

  logic              frame_start;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  modport master (
    output frame_start, pix_valid, pix_data,
    input  wr_en, wr_addr, wr_data, busy, frame_done, overrun
  );

  modport slave (
    input  frame_start, pix_valid, pix_data,
    output wr_en, wr_addr, wr_data, busy, frame_done, overrun
  );

endinterface

// File: rtl/ii_line_buffer.sv
// One-row line buffer holding ii(x, y-1) for every column.
// Simple dual-port RAM, II_WIDTH x DATA_W, synchronous one-cycle read,
// independent write port, no reset on contents (BRAM-inferable).
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request, data valid the cycle after
//   rd_data          : registered read data
module ii_line_buffer
  import ii_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [COL_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [COL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [II_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/integral_image_builder.sv
// Writer side of the integral-image frame store. Takes a raster-ordered
// pixel stream and writes ii(x,y) = ii(x,y-1) + row_sum(x,y) to the frame
// RAM at y*II_WIDTH + x, two cycles after each accepted pixel.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : pixel stream in, RAM write strobe/address/data and status out
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no frame armed; pixels are discarded and flag overrun
// RUN   | accepting pixels, col 0..159, row 0..119
// FLUSH | last pixel accepted, waiting for its write to issue
module integral_image_builder
  import ii_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  integral_image_builder_if.slave bus
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(II_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(II_HEIGHT - 1);

  ii_state_t         state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] row_sum;
  logic [ADDR_W-1:0] addr;
  ii_stage1_t        s1;

  logic              accept;
  logic              stray;
  logic              last_pix;
  logic              lb_we;
  logic [DATA_W-1:0] lb_rdata;
  logic [DATA_W-1:0] row_sum_next;
  logic [DATA_W-1:0] sum;

  // frame_start has priority over a coincident pixel.
  assign accept   = bus.pix_valid && !bus.frame_start && (state == RUN);
  assign stray    = bus.pix_valid && !bus.frame_start && (state != RUN);
  assign last_pix = (col == LAST_COL) && (row == LAST_ROW);

  assign row_sum_next = row_sum + DATA_W'(bus.pix_data);

  // Row 0 ignores the buffer, so stale data from a previous frame is harmless.
  assign sum   = (s1.row0 ? '0 : lb_rdata) + s1.row_sum;
  assign lb_we = s1.valid && !bus.frame_start;

  // Read for col x+1 and write for col x never collide; at a row wrap the
  // read is col 0 while the write is col 159.
  ii_line_buffer u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (s1.col),
    .wr_data (sum),
    .rd_en   (accept),
    .rd_addr (col),
    .rd_data (lb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      row_sum        <= '0;
      addr           <= '0;
      s1             <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
    end else if (bus.frame_start) begin
      // Abort whatever is in flight; a pending stage-1 write is dropped.
      state          <= RUN;
      col            <= '0;
      row            <= '0;
      row_sum        <= '0;
      addr           <= '0;
      s1.valid       <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b1;
      bus.overrun    <= 1'b0;
    end else begin
      if (stray) bus.overrun <= 1'b1;

      // Stage 1
      s1.valid <= accept;
      if (accept) begin
        s1.col     <= col;
        s1.row0    <= (row == '0);
        s1.last    <= last_pix;
        s1.row_sum <= row_sum_next;
        s1.addr    <= addr;
        addr       <= addr + 1'b1;
        if (col == LAST_COL) begin
          col     <= '0;
          row     <= row + 1'b1;
          row_sum <= '0;
        end else begin
          col     <= col + 1'b1;
          row_sum <= row_sum_next;
        end
      end

      // Stage 2
      bus.wr_en      <= s1.valid;
      bus.frame_done <= s1.valid && s1.last;
      if (s1.valid) begin
        bus.wr_addr <= s1.addr;
        bus.wr_data <= sum;
      end

      case (state)
        RUN: begin
          if (accept && last_pix) state <= FLUSH;
        end
        FLUSH: begin
          if (s1.valid && s1.last) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_integral_image_builder.sv
module tb_integral_image_builder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  integral_image_builder_if bus();

  integral_image_builder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int addr;
    int data;
    bit last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   iim[120][160];
  int   seen[19200];
  int   mx, my;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic fs, input logic pv, input logic [3:0] pd);
    @(posedge clk);
    #1;
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.pix_data    = pd;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0);
  endtask

  // Drops expectations whose write would issue after the frame_start edge.
  task automatic start_frame(input logic with_pix);
    step(1'b1, with_pix, 4'd5);
    while (q.size() != 0 && q[$].cyc > cyc) void'(q.pop_back());
    mx = 0;
    my = 0;
  endtask

  // Reference: ii from the summed-area recurrence over the 2-D pixel array.
  task automatic send_pixel(input int v);
    int s;
    exp_t e;
    step(1'b0, 1'b1, 4'(v));
    s = v;
    if (mx > 0) s += iim[my][mx-1];
    if (my > 0) s += iim[my-1][mx];
    if (mx > 0 && my > 0) s -= iim[my-1][mx-1];
    iim[my][mx] = s;
    e.addr = my * 160 + mx;
    e.data = s;
    e.last = (mx == 159 && my == 119);
    e.cyc  = cyc + 2;
    q.push_back(e);
    if (mx == 159) begin
      mx = 0;
      my++;
    end else begin
      mx++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
    check("idle_busy", bus.busy, 0);
    check("idle_frame_done", bus.frame_done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},      bus.wr_en, 0);
    check({tag, "_wr_addr"},    bus.wr_addr, 0);
    check({tag, "_wr_data"},    bus.wr_data, 0);
    check({tag, "_busy"},       bus.busy, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_overrun"},    bus.overrun, 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d at cyc %0d, expected no write",
                   bus.wr_addr, bus.wr_data, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.wr_addr !== 15'(e.addr) || bus.wr_data !== 20'(e.data) ||
              bus.frame_done !== e.last || cyc != e.cyc) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%0d done=%0b cyc=%0d, expected addr=%0d data=%0d done=%0b cyc=%0d",
                     bus.wr_addr, bus.wr_data, bus.frame_done, cyc, e.addr, e.data, e.last, e.cyc);
          end
        end
        if (int'(bus.wr_addr) < 19200) seen[bus.wr_addr] = int'(bus.wr_data);
      end else if (bus.frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done_without_write: got frame_done=1 wr_en=0 at cyc %0d, expected 0", cyc);
      end
    end
  end

  initial begin
    #950000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout at cyc %0d, expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int bad;
    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    mx = 0;
    my = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Frame A: all ones, continuous, then a pixel during FLUSH
    start_frame(1'b0);
    idle();
    @(negedge clk);
    check("busy_after_start", bus.busy, 1);
    for (int i = 0; i < 19200; i++) send_pixel(1);
    step(1'b0, 1'b1, 4'd3);
    idle();
    @(negedge clk);
    check("overrun_in_flush", bus.overrun, 1);
    drain();
    check("ones_addr159", seen[159], 160);
    check("ones_addr160", seen[160], 2);
    check("ones_addr19199", seen[19199], 19200);

    // Frame B: random pixels with random gaps
    start_frame(1'b0);
    idle();
    @(negedge clk);
    check("overrun_cleared_by_start", bus.overrun, 0);
    for (int i = 0; i < 19200; i++) begin
      while ($urandom_range(7) == 0) idle();
      send_pixel(int'($urandom_range(15)));
    end
    drain();

    // Frame C: 500 pixels every other cycle, abort, then a full frame of 15s
    start_frame(1'b0);
    for (int i = 0; i < 500; i++) begin
      idle();
      send_pixel(int'($urandom_range(15)));
    end
    start_frame(1'b0);
    idle();
    @(negedge clk);
    check("abort_overrun", bus.overrun, 0);
    check("abort_busy", bus.busy, 1);
    for (int i = 0; i < 19200; i++) send_pixel(15);
    drain();
    check("max_addr0", seen[0], 15);
    check("max_addr19199", seen[19199], 288000);
    check("abort_overrun_end", bus.overrun, 0);

    // Frame D: single pixel 7 at (3,2)
    start_frame(1'b0);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        send_pixel((x == 3 && y == 2) ? 7 : 0);
    drain();
    bad = 0;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        if (seen[y*160+x] != ((x >= 3 && y >= 2) ? 7 : 0)) bad++;
    check("single_pixel_region_bad_count", bad, 0);

    // Overrun in IDLE, then pixel coincident with frame_start
    step(1'b0, 1'b1, 4'd5);
    idle();
    @(negedge clk);
    check("overrun_idle_pixel", bus.overrun, 1);
    start_frame(1'b1);
    idle();
    @(negedge clk);
    check("overrun_after_start_with_pixel", bus.overrun, 0);
    check("busy_after_start_with_pixel", bus.busy, 1);
    repeat (3) idle();

    // Reset mid-row
    for (int i = 0; i < 80; i++) send_pixel(int'($urandom_range(1, 15)));
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrow_reset");
    q.delete();
    bus.pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) idle();
    @(negedge clk);
    check("post_reset_wr_en", bus.wr_en, 0);
    check("post_reset_busy", bus.busy, 0);
    check("post_reset_overrun", bus.overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
